// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer.
//
// Takes a raw payload byte stream and produces a complete GMII-style transmit
// byte stream: preamble, SFD, 14-byte MAC header, payload, zero pad up to the
// minimum payload size, FCS (CRC-32), then an inter-frame gap. Frames that
// underrun or exceed the maximum payload are aborted with a GMII error cycle
// and the remainder of the input frame is discarded.
//
// Ports:
//   i_clk          125 MHz Ethernet clock
//   i_rst_n        synchronous active-low reset
//   i_tx_valid     payload byte valid
//   i_tx_data      payload byte
//   i_tx_last      final payload byte of the frame
//   o_tx_ready     payload byte accepted when valid & ready (registered)
//   i_dst_mac      destination MAC, latched at frame start
//   i_src_mac      source MAC, latched at frame start
//   i_ethertype    EtherType/length, latched at frame start
//   o_txd          GMII transmit byte
//   o_tx_en        GMII transmit enable
//   o_tx_er        GMII transmit error
//   o_frame_done   1-cycle pulse with the final FCS byte of a good frame
//   o_frame_err    1-cycle pulse with the error byte of an aborted frame
//
// The state register names the phase that drives the outputs on the NEXT edge;
// every output is a register loaded on that edge.

module eth_tx_framer #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_PAYLOAD  = 46,
  parameter int unsigned MAX_PAYLOAD  = 1500,
  parameter int unsigned IFG_CYCLES   = 12
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_tx_valid,
  input  logic [7:0]  i_tx_data,
  input  logic        i_tx_last,
  output logic        o_tx_ready,
  input  logic [47:0] i_dst_mac,
  input  logic [47:0] i_src_mac,
  input  logic [15:0] i_ethertype,
  output logic [7:0]  o_txd,
  output logic        o_tx_en,
  output logic        o_tx_er,
  output logic        o_frame_done,
  output logic        o_frame_err
);

  typedef enum logic [3:0] {
    StIdle,
    StPreamble,
    StSfd,
    StHeader,
    StPayload,
    StPad,
    StFcs,
    StAbort,
    StDrain,
    StIfg
  } state_e;

  localparam logic [10:0] PreLen  = 11'(PREAMBLE_LEN);
  localparam logic [10:0] MinPay  = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MaxPay  = 11'(MAX_PAYLOAD);
  localparam logic [10:0] IfgCyc  = 11'(IFG_CYCLES);
  localparam logic [10:0] HdrLast = 11'd13;
  localparam logic [31:0] CrcPoly = 32'hEDB8_8320;

  state_e        state_q;
  logic [10:0]   cnt_q;   // preamble / header / payload / FCS / gap byte counter
  logic [111:0]  hdr_q;   // latched header, shifted out MSB first
  logic [31:0]   crc_q;   // running CRC register (not yet complemented)

  logic [10:0]   cnt_inc;
  logic [31:0]   fcs;
  logic [31:0]   fcs_sh;

  // Byte-serial reflected CRC-32 update.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  // Saturating increment so an absurdly long gap or drain can never wrap.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 11'd1;

  // FCS goes out complemented, least significant byte first.
  assign fcs    = ~crc_q;
  assign fcs_sh = fcs >> {cnt_q[1:0], 3'b000};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hdr_q        <= '0;
      crc_q        <= '1;
      o_tx_ready   <= 1'b0;
      o_txd        <= 8'h00;
      o_tx_en      <= 1'b0;
      o_tx_er      <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_tx_er      <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;

      unique case (state_q)
        StIdle: begin
          o_tx_en    <= 1'b0;
          o_txd      <= 8'h00;
          o_tx_ready <= 1'b0;
          // Valid only starts the frame here; the byte itself is consumed later.
          if (i_tx_valid) begin
            hdr_q   <= {i_dst_mac, i_src_mac, i_ethertype};
            o_tx_en <= 1'b1;
            o_txd   <= 8'h55;
            cnt_q   <= 11'd1;
            state_q <= (PreLen > 11'd1) ? StPreamble : StSfd;
          end
        end

        StPreamble: begin
          o_txd <= 8'h55;
          cnt_q <= cnt_inc;
          if (cnt_inc >= PreLen) begin
            state_q <= StSfd;
          end
        end

        StSfd: begin
          o_txd   <= 8'hD5;
          crc_q   <= '1;
          cnt_q   <= '0;
          state_q <= StHeader;
        end

        StHeader: begin
          o_txd <= hdr_q[111:104];
          crc_q <= crc_step(crc_q, hdr_q[111:104]);
          hdr_q <= hdr_q << 8;
          cnt_q <= cnt_inc;
          // Ready rises with the last header byte so the first payload byte
          // is accepted in time to follow it without a hole.
          if (cnt_q == HdrLast) begin
            o_tx_ready <= 1'b1;
            cnt_q      <= '0;
            state_q    <= StPayload;
          end
        end

        StPayload: begin
          if (!o_tx_ready || !i_tx_valid) begin
            // Ready already low here means the maximum payload was reached
            // without last; otherwise the source ran dry mid-frame.
            o_txd       <= 8'h00;
            o_tx_er     <= 1'b1;
            o_frame_err <= 1'b1;
            o_tx_ready  <= 1'b0;
            state_q     <= StAbort;
          end else begin
            o_txd <= i_tx_data;
            crc_q <= crc_step(crc_q, i_tx_data);
            cnt_q <= cnt_inc;
            if (i_tx_last) begin
              o_tx_ready <= 1'b0;
              if (cnt_inc < MinPay) begin
                state_q <= StPad;
              end else begin
                cnt_q   <= '0;
                state_q <= StFcs;
              end
            end else if (cnt_inc >= MaxPay) begin
              o_tx_ready <= 1'b0;
            end
          end
        end

        StPad: begin
          o_txd <= 8'h00;
          crc_q <= crc_step(crc_q, 8'h00);
          cnt_q <= cnt_inc;
          if (cnt_inc >= MinPay) begin
            cnt_q   <= '0;
            state_q <= StFcs;
          end
        end

        StFcs: begin
          o_txd <= fcs_sh[7:0];
          cnt_q <= cnt_inc;
          if (cnt_q == 11'd3) begin
            o_frame_done <= 1'b1;
            cnt_q        <= '0;
            state_q      <= StIfg;
          end
        end

        StAbort: begin
          // Both abort causes fire before last is accepted, so the rest of
          // the input frame always has to be drained.
          o_tx_en    <= 1'b0;
          o_txd      <= 8'h00;
          o_tx_ready <= 1'b1;
          state_q    <= StDrain;
        end

        StDrain: begin
          o_tx_en <= 1'b0;
          o_txd   <= 8'h00;
          if (i_tx_valid && i_tx_last) begin
            o_tx_ready <= 1'b0;
            cnt_q      <= '0;
            state_q    <= StIfg;
          end
        end

        StIfg: begin
          // The last gap cycle is the one spent in IDLE detecting the next
          // frame, so IDLE's own cycle is counted here.
          o_tx_en <= 1'b0;
          o_txd   <= 8'h00;
          cnt_q   <= cnt_inc;
          if (cnt_inc >= IfgCyc) begin
            state_q <= StIdle;
          end
        end

        default: begin
          o_tx_en    <= 1'b0;
          o_txd      <= 8'h00;
          o_tx_ready <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Randomized self-checking bench for eth_tx_framer. A driver pushes frames and
// builds each frame's expected GMII burst from the framing rules; a monitor
// captures every tx_en burst and compares it against that expectation.

module tb_eth_tx_framer;

  localparam int MinPay = 46;
  localparam int MaxPay = 1500;
  localparam int IfgCyc = 12;
  localparam int HdrEnd = 22;  // preamble + SFD + header bytes

  typedef struct packed {
    int   nbytes;
    int   kind;     // 0 good, 1 aborted, 2 cut by reset
    int   pl_out;   // payload bytes that reach o_txd
    logic chk_gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_tx_valid;
  logic [7:0]  i_tx_data;
  logic        i_tx_last;
  logic        o_tx_ready;
  logic [47:0] i_dst_mac;
  logic [47:0] i_src_mac;
  logic [15:0] i_ethertype;
  logic [7:0]  o_txd;
  logic        o_tx_en;
  logic        o_tx_er;
  logic        o_frame_done;
  logic        o_frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stray    = 0;
  logic prev_good = 1'b0;

  exp_t       exp_rec_q[$];
  logic [7:0] exp_byte_q[$];
  int         acc_q[$];

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eth_tx_framer dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_tx_valid   (i_tx_valid),
    .i_tx_data    (i_tx_data),
    .i_tx_last    (i_tx_last),
    .o_tx_ready   (o_tx_ready),
    .i_dst_mac    (i_dst_mac),
    .i_src_mac    (i_src_mac),
    .i_ethertype  (i_ethertype),
    .o_txd        (o_txd),
    .o_tx_en      (o_tx_en),
    .o_tx_er      (o_tx_er),
    .o_frame_done (o_frame_done),
    .o_frame_err  (o_frame_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bit-serial reflected CRC-32 (poly 0xEDB88320), register only, no final xor.
  function automatic logic [31:0] crc_feed(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] != b[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else r = r >> 1;
    end
    return r;
  endfunction

  task automatic check_idle_outputs(input string pfx);
    check_eq({pfx, "_txd"},   32'(o_txd), 0);
    check_eq({pfx, "_en"},    32'(o_tx_en), 0);
    check_eq({pfx, "_er"},    32'(o_tx_er), 0);
    check_eq({pfx, "_ready"}, 32'(o_tx_ready), 0);
    check_eq({pfx, "_done"},  32'(o_frame_done), 0);
    check_eq({pfx, "_err"},   32'(o_frame_err), 0);
  endtask

  // pat: 0 random bytes, 1 incrementing, 2 all 0xAB
  task automatic send_frame(input int len, input bit b2b, input int pat, input int drop_at,
                            input int rst_at, input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] et);
    logic [7:0]  pl[$];
    logic [7:0]  fb[$];
    logic [31:0] crc;
    exp_t        r;
    int          kind, k, idx, budget;
    bit          dropped, junked;

    for (int i = 0; i < len; i++) begin
      if (pat == 1)      pl.push_back(8'(i));
      else if (pat == 2) pl.push_back(8'hAB);
      else               pl.push_back(8'($urandom()));
    end

    for (int i = 0; i < 6; i++) fb.push_back(dst[47 - 8*i -: 8]);
    for (int i = 0; i < 6; i++) fb.push_back(src[47 - 8*i -: 8]);
    fb.push_back(et[15:8]);
    fb.push_back(et[7:0]);

    if (rst_at >= 0)       begin kind = 2; k = rst_at; end
    else if (drop_at >= 0) begin kind = 1; k = drop_at; end
    else if (len > MaxPay) begin kind = 1; k = MaxPay; end
    else                   begin kind = 0; k = len; end

    for (int i = 0; i < k; i++) fb.push_back(pl[i]);
    if (kind == 0) begin
      while (fb.size() < 14 + MinPay) fb.push_back(8'h00);
      crc = 32'hFFFF_FFFF;
      foreach (fb[i]) crc = crc_feed(crc, fb[i]);
      crc = ~crc;
      for (int i = 0; i < 4; i++) fb.push_back(crc[8*i +: 8]);
    end else if (kind == 1) begin
      fb.push_back(8'h00);
    end

    for (int i = 0; i < 7; i++) exp_byte_q.push_back(8'h55);
    exp_byte_q.push_back(8'hD5);
    foreach (fb[i]) exp_byte_q.push_back(fb[i]);
    r.nbytes  = 8 + fb.size();
    r.kind    = kind;
    r.pl_out  = k;
    r.chk_gap = b2b && prev_good;
    exp_rec_q.push_back(r);

    if (!b2b) begin
      @(negedge clk);
      i_tx_valid = 1'b0;
      i_tx_last  = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    i_dst_mac   = dst;
    i_src_mac   = src;
    i_ethertype = et;

    idx = 0; budget = 0; dropped = 0; junked = 0;
    while (idx < len) begin
      @(negedge clk);
      budget++;
      if (budget > 4000) begin
        check_eq("ready_timeout", 32'(idx), 32'(len));
        break;
      end
      // Port changes after the frame has started must not reach this frame.
      if (idx == 1 && !junked) begin
        i_dst_mac   = {$urandom(), $urandom()};
        i_src_mac   = {$urandom(), $urandom()};
        i_ethertype = 16'($urandom());
        junked      = 1;
      end
      if (rst_at >= 0 && idx == rst_at) begin
        i_rst_n    = 1'b0;
        i_tx_valid = 1'b0;
        i_tx_last  = 1'b0;
        @(negedge clk);
        check_idle_outputs("midframe_rst");
        i_rst_n = 1'b1;
        break;
      end
      if (drop_at >= 0 && idx == drop_at && !dropped) begin
        i_tx_valid = 1'b0;
        dropped    = 1;
      end else begin
        i_tx_valid = 1'b1;
        i_tx_data  = pl[idx];
        i_tx_last  = (idx == len - 1);
        if (o_tx_ready) begin
          if (idx < k) acc_q.push_back(cyc + 1);
          idx++;
        end
      end
    end
    prev_good = (kind == 0);
  endtask

  // ---------------- monitor ----------------
  logic [7:0] b_data[$];
  int         b_cyc[$];
  logic       b_rdy[$];
  int er_pos, er_cnt, done_pos, done_cnt, err_pos, err_cnt;
  int low_cnt = 0;
  bit in_burst = 0;

  task automatic end_burst();
    exp_t        r;
    int          n, nmis, lat_err, a, last_i;
    logic [31:0] res;
    logic [7:0]  e;
    n = b_data.size();
    if (exp_rec_q.size() == 0) begin
      check_eq("unexpected_burst_len", 32'(n), 0);
      return;
    end
    r = exp_rec_q.pop_front();
    check_eq("burst_len", 32'(n), 32'(r.nbytes));
    nmis = 0;
    for (int i = 0; i < r.nbytes; i++) begin
      e = exp_byte_q.pop_front();
      if (i >= n || b_data[i] !== e) nmis++;
    end
    check_eq("byte_mismatches", 32'(nmis), 0);
    if (n >= HdrEnd) begin
      check_eq("ready_before_last_hdr", 32'(b_rdy[HdrEnd-2]), 0);
      check_eq("ready_on_last_hdr", 32'(b_rdy[HdrEnd-1]), 1);
    end
    lat_err = 0;
    for (int i = 0; i < r.pl_out; i++) begin
      a = acc_q.pop_front();
      if (HdrEnd + i >= n || b_cyc[HdrEnd + i] != a) lat_err++;
    end
    check_eq("accept_to_txd_latency", 32'(lat_err), 0);
    last_i = r.nbytes - 1;
    check_eq("done_pos", 32'(done_pos), (r.kind == 0) ? 32'(last_i) : 32'hFFFF_FFFF);
    check_eq("done_cnt", 32'(done_cnt), (r.kind == 0) ? 1 : 0);
    check_eq("err_pos", 32'(err_pos), (r.kind == 1) ? 32'(last_i) : 32'hFFFF_FFFF);
    check_eq("err_cnt", 32'(err_cnt), (r.kind == 1) ? 1 : 0);
    check_eq("er_pos", 32'(er_pos), (r.kind == 1) ? 32'(last_i) : 32'hFFFF_FFFF);
    check_eq("er_cnt", 32'(er_cnt), (r.kind == 1) ? 1 : 0);
    if (r.kind == 0 && n > 8) begin
      res = 32'hFFFF_FFFF;
      for (int i = 8; i < n; i++) res = crc_feed(res, b_data[i]);
      check_eq("crc_residue", res, 32'hDEBB_20E3);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (o_tx_en) begin
        if (!in_burst) begin
          in_burst = 1;
          if (exp_rec_q.size() > 0 && exp_rec_q[0].chk_gap)
            check_eq("ifg_len", 32'(low_cnt), 32'(IfgCyc));
          b_data.delete(); b_cyc.delete(); b_rdy.delete();
          er_pos = -1; er_cnt = 0; done_pos = -1; done_cnt = 0; err_pos = -1; err_cnt = 0;
        end
        if (o_tx_er)      begin if (er_pos < 0) er_pos = b_data.size(); er_cnt++; end
        if (o_frame_done) begin if (done_pos < 0) done_pos = b_data.size(); done_cnt++; end
        if (o_frame_err)  begin if (err_pos < 0) err_pos = b_data.size(); err_cnt++; end
        b_data.push_back(o_txd);
        b_cyc.push_back(cyc);
        b_rdy.push_back(o_tx_ready);
      end else begin
        if (o_tx_er || o_frame_done || o_frame_err) stray++;
        if (in_burst) begin
          end_burst();
          in_burst = 0;
          low_cnt  = 1;
        end else begin
          low_cnt++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    i_rst_n = 1'b0; i_tx_valid = 1'b0; i_tx_data = 8'h00; i_tx_last = 1'b0;
    i_dst_mac = '0; i_src_mac = '0; i_ethertype = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    i_rst_n = 1'b1;

    send_frame(1, 0, 2, -1, -1, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800);
    send_frame(100, 0, 1, -1, -1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 16'h0800);
    send_frame(60, 0, 0, -1, -1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 16'h86DD);
    send_frame(60, 1, 0, -1, -1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 16'h0806);
    send_frame(40, 1, 0, 10, -1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 16'h0800);
    send_frame(45, 1, 0, -1, -1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 16'h0800);
    send_frame(46, 1, 0, -1, -1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 16'h0800);
    send_frame(47, 1, 0, -1, -1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 16'h0800);
    send_frame(1500, 1, 0, -1, -1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 16'h0800);
    send_frame(1501, 1, 0, -1, -1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 16'h0800);
    send_frame(64, 1, 0, -1, -1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 16'h0800);
    send_frame(64, 0, 0, -1, 30, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 16'h0800);
    send_frame(80, 0, 0, -1, -1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 16'h0800);
    for (int f = 0; f < 8; f++) begin
      send_frame($urandom_range(1, 200), 1'($urandom_range(0, 1)), 0, -1, -1,
                 {$urandom(), $urandom()}, {$urandom(), $urandom()}, 16'($urandom()));
    end

    @(negedge clk);
    i_tx_valid = 1'b0;
    i_tx_last  = 1'b0;
    for (int w = 0; w < 4000 && exp_rec_q.size() != 0; w++) @(negedge clk);
    repeat (4) @(negedge clk);
    check_eq("pending_frames", 32'(exp_rec_q.size()), 0);
    check_eq("stray_pulses", 32'(stray), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_tx_framer.md
Name: eth_tx_framer

Overview:
- Transmit-direction counterpart of the raw Ethernet receive path.
- Accepts a raw payload byte stream (valid/data/last/ready) and emits a complete GMII-style byte stream on the 125 MHz Ethernet clock: preamble, SFD, 14-byte header, payload, zero pad, FCS, then inter-frame gap.
- The output feeds the RGMII TX PHY interface.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes before SFD
MIN_PAYLOAD, 46, payloads shorter than this are zero-padded to it
MAX_PAYLOAD, 1500, longest legal payload; a longer frame is aborted
IFG_CYCLES, 12, idle cycles between consecutive frames (o_tx_en low)

Ports:
i_clk  in  1  125 MHz Ethernet clock
i_rst_n  in  1  synchronous active-low reset
i_tx_valid  in  1  payload byte valid
i_tx_data  in  8  payload byte
i_tx_last  in  1  marks final payload byte of frame
o_tx_ready  out  1  payload byte accepted when valid&ready
i_dst_mac  in  48  destination MAC, sampled at frame start
i_src_mac  in  48  source MAC, sampled at frame start
i_ethertype  in  16  EtherType/length, sampled at frame start
o_txd  out  8  GMII transmit byte
o_tx_en  out  1  GMII transmit enable
o_tx_er  out  1  GMII transmit error
o_frame_done  out  1  1-cycle pulse on final FCS byte of a good frame
o_frame_err  out  1  1-cycle pulse on underrun/oversize abort

Behaviour:
- Reset (i_rst_n=0 at edge): state IDLE; o_txd=0, o_tx_en=0, o_tx_er=0, o_tx_ready=0, pulses 0. A reset mid-frame drops o_tx_en on that edge with no FCS and no drain.
- All outputs are registered. o_tx_ready is registered and high only in PAYLOAD and DRAIN.
- States: IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, PAD, FCS, ABORT, DRAIN, IFG.
- IDLE:
  - On i_tx_valid=1 (byte not consumed), latch the MAC and EtherType ports and go to PREAMBLE.
  - Later port changes are ignored until the next frame.
- PREAMBLE: PREAMBLE_LEN cycles of 0x55. SFD: one cycle of 0xD5.
- HEADER:
  - 14 bytes, MSB first: dst[47:40]..dst[7:0], then src likewise, then ethertype[15:8], ethertype[7:0].
  - o_tx_ready rises so that it is high in the cycle the last header byte is on o_txd.
- PAYLOAD:
  - Each accepted byte appears on o_txd one cycle after acceptance; o_tx_en stays high continuously.
  - On accepted i_tx_last: if count < MIN_PAYLOAD go to PAD, else go to FCS. o_tx_ready drops on the edge after acceptance of last.
- PAD: 0x00 bytes until payload+pad = MIN_PAYLOAD.
- FCS:
  - CRC-32, reflected poly 0xEDB88320, init 0xFFFFFFFF.
  - Computed over header+payload+pad, excluding preamble and SFD.
  - Transmit the complement, low byte first, over 4 cycles. o_frame_done pulses with the 4th byte.
- Underrun: i_tx_valid=0 while in PAYLOAD with o_tx_ready=1 goes to ABORT.
- Oversize: MAX_PAYLOAD bytes accepted without last goes to ABORT.
- ABORT:
  - One cycle with o_tx_en=1, o_tx_er=1, o_txd=0x00, and o_frame_err pulse.
  - Then DRAIN if last has not yet been accepted, else IFG.
- DRAIN: o_tx_en=0, o_tx_ready=1, discard bytes until i_tx_last accepted, then IFG.
- IFG:
  - o_tx_en=0, o_txd=0.
  - With continuous input, o_tx_en is low for exactly IFG_CYCLES cycles between frames; the IDLE detection cycle counts toward the gap.
- Counters:
  - Byte counter is 11 bits and saturates.
  - o_tx_er=0 in every state except ABORT.

Test Plan:
- 1-byte payload 0xAB, dst=FF..FF, src=02:00:00:00:00:01, type=0x0800:
  - o_tx_en high 72 consecutive cycles: 7×0x55, 0xD5, header, 0xAB, 45×0x00, 4 FCS.
  - FCS matches the software CRC, and the CRC residue over header..FCS is 0xDEBB20E3.
- 100-byte incrementing payload, valid held high:
  - No pad; 126 tx_en cycles; each byte appears one cycle after acceptance.
  - o_frame_done pulses once, on the final FCS byte.
- Two back-to-back 60-byte frames, valid always high:
  - o_tx_en low for exactly 12 cycles between frames.
  - Second frame carries the second set of latched MACs even though the ports change mid-first-frame.
- Drop valid for 1 cycle after payload byte 10:
  - Next cycle has tx_en=1, tx_er=1, o_frame_err pulse.
  - Remaining bytes are drained with tx_en=0 until last; IFG follows; no FCS is emitted.
- 1501-byte payload:
  - Abort after the 1500th byte is output; remaining byte drained.
  - Next frame is then transmitted correctly.
- Assert i_rst_n=0 during byte 30 of a frame:
  - All outputs 0 on that edge; state IDLE.
  - After release, a new frame transmits normally.
